// File: rtl/bmem_pkg.sv
// Shared types and default geometry for the cache-line to burst-memory adapter.
package bmem_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_BEAT_W = 64;
  localparam int BEATS      = DEF_LINE_W / DEF_BEAT_W;
  localparam int CNT_W      = $clog2(BEATS);
  localparam int OFFSET_W   = $clog2(DEF_LINE_W / 8);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_BEATS, WR_BEATS, WR_WAIT, DONE} bmem_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} bmem_owner_t;
endpackage

// File: rtl/bmem_line_buf.sv
// Line buffer shared by read reassembly and write serialisation, with its beat counter.
module bmem_line_buf import bmem_pkg::*; #(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ld,
  input  logic [LINE_W-1:0]                   ld_line,
  input  logic                                st,
  input  logic [BEAT_W-1:0]                   st_beat,
  input  logic                                adv,
  output logic [LINE_W-1:0]                   line,
  output logic [BEAT_W-1:0]                   beat,
  output logic [$clog2(LINE_W/BEAT_W)-1:0]    cnt
);
  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CW     = $clog2(NBEATS);

  logic [LINE_W-1:0] line_d, line_q;
  logic [CW-1:0]     cnt_d, cnt_q;

  // Counter wraps naturally on the last beat, which is always a state exit.
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (ld) begin
      line_d = ld_line;
      cnt_d  = '0;
    end else begin
      if (st) line_d[cnt_q*BEAT_W +: BEAT_W] = st_beat;
      if (st || adv) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line = line_q;
  assign beat = line_q[cnt_q*BEAT_W +: BEAT_W];
  assign cnt  = cnt_q;
endmodule

// File: rtl/bmem_line_adapter.sv
// Arbitrates I/D cache line requests (D first) onto a beat-serial burst memory port.
module bmem_line_adapter import bmem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int BEAT_W = DEF_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  input  logic [BEAT_W-1:0] bmem_rdata,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_resp
);
  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CW     = $clog2(NBEATS);
  localparam int OFFW   = $clog2(LINE_W / 8);

  bmem_state_t       state_d, state_q;
  bmem_owner_t       owner_d, owner_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              wr_d, wr_q;
  logic              wr_ack_d, wr_ack_q;

  logic              buf_ld, buf_st, buf_adv;
  logic [LINE_W-1:0] buf_ld_line, line;
  logic [BEAT_W-1:0] beat;
  logic [CW-1:0]     cnt;
  logic              last_beat;

  logic unused_offs;
  assign unused_offs = ^{i_addr[OFFW-1:0], d_addr[OFFW-1:0]};

  assign last_beat = (cnt == CW'(NBEATS-1));

  bmem_line_buf #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_buf (
    .clk(clk), .rst(rst),
    .ld(buf_ld), .ld_line(buf_ld_line),
    .st(buf_st), .st_beat(bmem_rdata),
    .adv(buf_adv),
    .line(line), .beat(beat), .cnt(cnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wr_ack_d    = wr_ack_q;
    buf_ld      = 1'b0;
    buf_ld_line = '0;
    buf_st      = 1'b0;
    buf_adv     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ack_d = 1'b0;
        if (d_write || d_read) begin
          owner_d = OWN_D;
          addr_d  = {d_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
          wr_d    = d_write;
          buf_ld  = 1'b1;
          if (d_write) begin
            buf_ld_line = d_wdata;
            state_d     = WR_BEATS;
          end else begin
            state_d     = RD_CMD;
          end
        end else if (i_read) begin
          owner_d = OWN_I;
          addr_d  = {i_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
          wr_d    = 1'b0;
          buf_ld  = 1'b1;
          state_d = RD_CMD;
        end
      end
      RD_CMD: state_d = RD_BEATS;
      RD_BEATS: begin
        if (bmem_resp) begin
          buf_st = 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WR_BEATS: begin
        buf_adv = 1'b1;
        // Memory may accept the burst early; remember it for WR_WAIT.
        if (bmem_resp) wr_ack_d = 1'b1;
        if (last_beat) state_d = WR_WAIT;
      end
      WR_WAIT: if (bmem_resp || wr_ack_q) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  always @(posedge clk)
    if (!rst && bmem_resp)
      assert (state_q == RD_BEATS || state_q == WR_BEATS || state_q == WR_WAIT);

  // Outputs decode registered state only; bmem_rdata never reaches the caches combinationally.
  assign bmem_address = addr_q;
  assign bmem_read    = (state_q == RD_CMD);
  assign bmem_write   = (state_q == WR_BEATS);
  assign bmem_wdata   = bmem_write ? beat : '0;
  assign i_resp       = (state_q == DONE) && (owner_q == OWN_I);
  assign d_resp       = (state_q == DONE) && (owner_q == OWN_D);
  assign i_rdata      = i_resp ? line : '0;
  assign d_rdata      = (d_resp && !wr_q) ? line : '0;
endmodule
